// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the serial-memory engine between CPU (0) and debug loader (1),
// one transaction at a time, round-robin on ties, with a watchdog abort in WAIT.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 256
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [1:0]        req_i,
  input  logic [1:0]        rwb_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              cpu_halt_o,
  output logic              eng_start_o,
  output logic              eng_rwb_o,
  output logic [ADDR_W-1:0] eng_addr_o,
  output logic [DATA_W-1:0] eng_data_o,
  output logic              eng_abort_o,
  input  logic              eng_done_i,
  input  logic [DATA_W-1:0] eng_rdata_i
);
  localparam int CW = $clog2(TMO_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;
  state_t state, state_n;
  logic owner, owner_n, last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] gnt_n, done_n;
  logic err_n, start_n, rwb_n, abort_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n, rdata_n;
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    cnt_n   = cnt;
    gnt_n   = gnt_o;
    done_n  = 2'b00;
    err_n   = 1'b0;
    start_n = 1'b0;
    abort_n = 1'b0;
    rwb_n   = eng_rwb_o;
    addr_n  = eng_addr_o;
    data_n  = eng_data_o;
    rdata_n = rdata_o;
    case (state)
      IDLE: if (|req_i) begin
        owner_n = &req_i ? ~last : req_i[1];
        gnt_n   = owner_n ? 2'b10 : 2'b01;
        rwb_n   = rwb_i[owner_n];
        addr_n  = owner_n ? addr1_i : addr0_i;
        data_n  = owner_n ? wdata1_i : wdata0_i;
        start_n = 1'b1;
        state_n = ISSUE;
      end
      ISSUE: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: if (eng_done_i) begin
        done_n  = owner ? 2'b10 : 2'b01;
        rdata_n = eng_rwb_o ? eng_rdata_i : rdata_o;
        state_n = COMPLETE;
      end else if (cnt == CW'(TMO_CYC - 1)) begin
        // engine hung: force it idle and report the transaction as failed
        done_n  = owner ? 2'b10 : 2'b01;
        err_n   = 1'b1;
        abort_n = 1'b1;
        state_n = COMPLETE;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      COMPLETE: begin
        last_n  = owner;
        gnt_n   = 2'b00;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      cnt         <= '0;
      gnt_o       <= 2'b00;
      done_o      <= 2'b00;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      cpu_halt_o  <= 1'b0;
      eng_start_o <= 1'b0;
      eng_rwb_o   <= 1'b0;
      eng_addr_o  <= '0;
      eng_data_o  <= '0;
      eng_abort_o <= 1'b0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      last        <= last_n;
      cnt         <= cnt_n;
      gnt_o       <= gnt_n;
      done_o      <= done_n;
      err_o       <= err_n;
      rdata_o     <= rdata_n;
      cpu_halt_o  <= gnt_n[1];
      eng_start_o <= start_n;
      eng_rwb_o   <= rwb_n;
      eng_addr_o  <= addr_n;
      eng_data_o  <= data_n;
      eng_abort_o <= abort_n;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, hand-built corner sequences and randomized transactions
// checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int TMO = 8;
  logic clk = 1'b0, resetb = 1'b0;
  logic [1:0] req_i = '0, rwb_i = '0, gnt_o, done_o;
  logic [15:0] addr0_i = '0, addr1_i = '0, wdata0_i = '0, wdata1_i = '0, eng_rdata_i = '0;
  logic [15:0] rdata_o, eng_addr_o, eng_data_o;
  logic err_o, cpu_halt_o, eng_start_o, eng_rwb_o, eng_abort_o, eng_done_i = 1'b0;
  int checks = 0, failures = 0;
  logic m_last;
  logic [15:0] m_rd;

  typedef struct {
    logic [1:0] g; logic e, rw, stable, halt, idle_ok;
    logic [15:0] rd, ad, dt;
    int cyc, starts, aborts;
  } res_t;

  typedef struct {
    logic [1:0] req, rwb; logic [15:0] a0, a1, w0, w1, erd; int lat;
    logic [1:0] gnt; logic err; logic [15:0] rd, addr, data; logic rwbe; int cyc;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TMO_CYC(TMO)) dut (
    .clk(clk), .resetb(resetb), .req_i(req_i), .rwb_i(rwb_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .cpu_halt_o(cpu_halt_o), .eng_start_o(eng_start_o), .eng_rwb_o(eng_rwb_o),
    .eng_addr_o(eng_addr_o), .eng_data_o(eng_data_o), .eng_abort_o(eng_abort_o),
    .eng_done_i(eng_done_i), .eng_rdata_i(eng_rdata_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {gnt_o, done_o, err_o, rdata_o, cpu_halt_o, eng_start_o, eng_rwb_o,
            eng_addr_o, eng_data_o, eng_abort_o};
  endfunction

  task automatic do_reset;
    resetb = 1'b0; req_i = '0; rwb_i = '0; eng_done_i = 1'b0;
    tick;
    tick;
    chk("reset_outputs", all_outs(), 64'd0);
    resetb = 1'b1;
    tick;
    m_last = 1'b1;
    m_rd = '0;
  endtask

  // Drives one request, emulates an engine answering lat cycles after its start pulse
  // (lat=0: never answers), and records what the arbiter did.
  task automatic run_txn(input logic [1:0] req, input logic [1:0] rwb, input logic [15:0] a0,
                         input logic [15:0] a1, input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] erd, input int lat, output res_t r);
    int sc = -1;
    r.g = '0; r.e = 1'b0; r.rw = 1'b0; r.stable = 1'b1; r.halt = 1'b0; r.idle_ok = 1'b0;
    r.rd = '0; r.ad = '0; r.dt = '0; r.cyc = -1; r.starts = 0; r.aborts = 0;
    req_i = req; rwb_i = rwb; addr0_i = a0; addr1_i = a1; wdata0_i = w0; wdata1_i = w1;
    eng_rdata_i = erd;
    for (int n = 1; n <= 40; n++) begin
      tick;
      eng_done_i = 1'b0;
      if (eng_start_o) begin
        r.starts++;
        if (sc < 0) begin
          sc = n; r.ad = eng_addr_o; r.dt = eng_data_o; r.rw = eng_rwb_o;
        end
      end else if (sc >= 0 && {eng_addr_o, eng_data_o, eng_rwb_o} !== {r.ad, r.dt, r.rw})
        r.stable = 1'b0;
      if (eng_abort_o) r.aborts++;
      if (done_o != 2'b00) begin
        r.g = done_o; r.e = err_o; r.rd = rdata_o; r.halt = cpu_halt_o; r.cyc = n + 1;
        break;
      end
      if (sc >= 0 && lat > 0 && n == sc + lat) eng_done_i = 1'b1;
    end
    req_i = '0;
    eng_done_i = 1'b0;
    tick;
    r.idle_ok = (gnt_o == 2'b00 && done_o == 2'b00 && cpu_halt_o == 1'b0);
  endtask

  // Transaction-level expectations: who wins, how long it takes, what data comes back.
  task automatic check_txn(input string tag, input logic [1:0] req, input logic [1:0] rwb,
                           input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] erd, input int lat);
    res_t r;
    logic own, to;
    logic [15:0] exp_rd;
    own = (req == 2'b11) ? ~m_last : req[1];
    to = (lat == 0 || lat > TMO);
    exp_rd = (!to && rwb[own]) ? erd : m_rd;
    run_txn(req, rwb, a0, a1, w0, w1, erd, lat, r);
    chk($sformatf("%s.done_owner", tag), r.g, own ? 2'b10 : 2'b01);
    chk($sformatf("%s.err", tag), r.e, to);
    chk($sformatf("%s.rdata", tag), r.rd, exp_rd);
    chk($sformatf("%s.latency", tag), r.cyc, to ? TMO + 3 : lat + 3);
    chk($sformatf("%s.starts", tag), r.starts, 1);
    chk($sformatf("%s.aborts", tag), r.aborts, to ? 1 : 0);
    chk($sformatf("%s.eng_addr", tag), r.ad, own ? a1 : a0);
    chk($sformatf("%s.eng_data", tag), r.dt, own ? w1 : w0);
    chk($sformatf("%s.eng_rwb", tag), r.rw, rwb[own]);
    chk($sformatf("%s.stable", tag), r.stable, 1'b1);
    chk($sformatf("%s.halt", tag), r.halt, own);
    chk($sformatf("%s.idle", tag), r.idle_ok, 1'b1);
    m_last = own;
    m_rd = exp_rd;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    res_t r;
    logic [3:0] ord;
    int k, halt_bad;
    logic pend;
    tbl[0] = '{2'b01, 2'b01, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 3, 2'b01, 1'b0, 16'hBEEF, 16'h0010, 16'h0000, 1'b1, 6};
    tbl[1] = '{2'b10, 2'b00, 16'h0000, 16'h0200, 16'h0000, 16'h1234, 16'h5555, 2, 2'b10, 1'b0, 16'hBEEF, 16'h0200, 16'h1234, 1'b0, 5};
    tbl[2] = '{2'b11, 2'b11, 16'h1000, 16'h2000, 16'h0A0A, 16'h0B0B, 16'h1111, 1, 2'b01, 1'b0, 16'h1111, 16'h1000, 16'h0A0A, 1'b1, 4};
    tbl[3] = '{2'b11, 2'b11, 16'h1000, 16'h2000, 16'h0A0A, 16'h0B0B, 16'h2222, 2, 2'b10, 1'b0, 16'h2222, 16'h2000, 16'h0B0B, 1'b1, 5};
    tbl[4] = '{2'b11, 2'b11, 16'h1000, 16'h2000, 16'h0A0A, 16'h0B0B, 16'h3333, 4, 2'b01, 1'b0, 16'h3333, 16'h1000, 16'h0A0A, 1'b1, 7};
    tbl[5] = '{2'b11, 2'b01, 16'h1000, 16'h2000, 16'h0A0A, 16'h0B0B, 16'h4444, 1, 2'b10, 1'b0, 16'h3333, 16'h2000, 16'h0B0B, 1'b0, 4};
    tbl[6] = '{2'b01, 2'b01, 16'h0030, 16'h0000, 16'h00C0, 16'h0000, 16'hDEAD, 0, 2'b01, 1'b1, 16'h3333, 16'h0030, 16'h00C0, 1'b1, 11};
    tbl[7] = '{2'b01, 2'b01, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 16'h8888, 8, 2'b01, 1'b0, 16'h8888, 16'h0040, 16'h0000, 1'b1, 11};
    tbl[8] = '{2'b10, 2'b10, 16'h0000, 16'h0050, 16'h0000, 16'h0000, 16'h9999, 9, 2'b10, 1'b1, 16'h8888, 16'h0050, 16'h0000, 1'b1, 11};
    do_reset;
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].req, tbl[i].rwb, tbl[i].a0, tbl[i].a1, tbl[i].w0, tbl[i].w1, tbl[i].erd, tbl[i].lat, r);
      chk($sformatf("vec%0d.done_owner", i), r.g, tbl[i].gnt);
      chk($sformatf("vec%0d.err", i), r.e, tbl[i].err);
      chk($sformatf("vec%0d.rdata", i), r.rd, tbl[i].rd);
      chk($sformatf("vec%0d.latency", i), r.cyc, tbl[i].cyc);
      chk($sformatf("vec%0d.eng_addr", i), r.ad, tbl[i].addr);
      chk($sformatf("vec%0d.eng_data", i), r.dt, tbl[i].data);
      chk($sformatf("vec%0d.eng_rwb", i), r.rw, tbl[i].rwbe);
      chk($sformatf("vec%0d.starts", i), r.starts, 1);
      chk($sformatf("vec%0d.aborts", i), r.aborts, tbl[i].err ? 1 : 0);
      chk($sformatf("vec%0d.stable", i), r.stable, 1'b1);
      chk($sformatf("vec%0d.halt", i), r.halt, tbl[i].gnt[1]);
      chk($sformatf("vec%0d.idle", i), r.idle_ok, 1'b1);
    end

    // both requesters held continuously: strict alternation starting with the CPU
    do_reset;
    req_i = 2'b11; rwb_i = 2'b00; ord = '0; k = 0; halt_bad = 0; pend = 1'b0;
    for (int n = 0; n < 60 && k < 4; n++) begin
      tick;
      eng_done_i = 1'b0;
      if (cpu_halt_o !== gnt_o[1] || (gnt_o == 2'b00 && cpu_halt_o)) halt_bad++;
      if (eng_start_o) pend = 1'b1;
      else if (pend) begin eng_done_i = 1'b1; pend = 1'b0; end
      if (done_o != 2'b00) begin
        ord = {ord[2:0], done_o[1]};
        if (cpu_halt_o !== done_o[1]) halt_bad++;
        k++;
      end
    end
    req_i = '0; eng_done_i = 1'b0;
    tick;
    chk("rr_count", k, 4);
    chk("rr_order", ord, 4'b0101);
    chk("rr_halt", halt_bad, 0);

    // asynchronous reset while waiting on a silent engine
    do_reset;
    req_i = 2'b01; rwb_i = 2'b01; addr0_i = 16'h0077;
    repeat (4) tick;
    chk("arst_pre_gnt", gnt_o, 2'b01);
    #2 resetb = 1'b0;
    #1 chk("arst_outputs", all_outs(), 64'd0);
    #2 resetb = 1'b1;
    m_last = 1'b1;
    m_rd = '0;
    check_txn("arst_restart", 2'b01, 2'b01, 16'h0077, 16'h0000, 16'h0000, 16'h0000, 16'h6161, 1);

    // engine done pulses in IDLE and ISSUE are ignored; request dropped in WAIT still completes
    eng_done_i = 1'b1;
    tick;
    chk("spur_idle", {done_o, gnt_o}, 4'b0000);
    req_i = 2'b01; rwb_i = 2'b01; addr0_i = 16'h0099; eng_rdata_i = 16'h1357;
    tick;
    chk("spur_issue_start", eng_start_o, 1'b1);
    tick;
    chk("spur_issue_nodone", done_o, 2'b00);
    eng_done_i = 1'b0; req_i = '0; eng_rdata_i = 16'hA5A5;
    tick;
    chk("spur_wait_nodone", done_o, 2'b00);
    eng_done_i = 1'b1;
    tick;
    eng_done_i = 1'b0;
    chk("drop_done", {done_o, err_o}, {2'b01, 1'b0});
    chk("drop_rdata", rdata_o, 16'hA5A5);
    tick;
    chk("drop_idle", {gnt_o, done_o}, 4'b0000);
    m_last = 1'b0;
    m_rd = 16'hA5A5;

    for (int i = 0; i < 60; i++) begin
      check_txn($sformatf("rnd%0d", i), 2'($urandom_range(1, 3)), 2'($urandom),
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                int'($urandom_range(0, 11)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
